conv_encoder_framed: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder with frame termination. It is the transmit end of the Viterbi link. It accepts a serial bit stream and emits one 2-bit code symbol per accepted bit. After every FRAME_LEN data bits it appends two zero tail bits, which return the trellis to state 00 so the receiving decoder starts every frame from a known state. It sits between the bit source and the channel/error-injection stage, and drives the decoder's symbol input.

---
 rtl/conv_encoder_framed.sv | 149 ++++++++++++++
 tb/tb_conv_encoder_framed.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framed.sv
`default_nettype none
// ============================================================================
// conv_encoder_framed : rate-1/2, K=3 convolutional encoder (G0=7, G1=5) that
// flushes the trellis with two zero tail bits after every FRAME_LEN data bits.
// Revision: 1.0
// ============================================================================
module conv_encoder_framed #(
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        d_in,
    output logic        ready_o,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        sof_o,
    output logic        eof_o,
    output logic [15:0] frame_ct_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1;
    logic               r_s2;
    logic               w_s1_nxt;
    logic               w_s2_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_count_inc;
    logic               r_tail_idx;
    logic               w_tail_idx_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [1:0]         r_dout;
    logic [1:0]         w_dout_nxt;
    logic               r_sof;
    logic               w_sof_nxt;
    logic               r_eof;
    logic               w_eof_nxt;
    logic [15:0]        r_frame_ct;
    logic [15:0]        w_frame_ct_nxt;
    logic               w_encode;
    logic               w_bit;

    // Count is zero in IDLE, so a plain increment also yields 1 for the first bit.
    assign w_count_inc = r_count + c_cnt_one;

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_tail_idx_nxt = r_tail_idx;
        w_frame_ct_nxt = r_frame_ct;
        w_dout_nxt     = r_dout;
        w_s1_nxt       = r_s1;
        w_s2_nxt       = r_s2;
        w_valid_nxt    = 1'b0;
        w_sof_nxt      = 1'b0;
        w_eof_nxt      = 1'b0;
        w_encode       = 1'b0;
        w_bit          = 1'b0;

        case (r_state)
            S_IDLE, S_DATA: begin
                if (enable_i) begin
                    w_encode    = 1'b1;
                    w_bit       = d_in;
                    w_count_nxt = w_count_inc;
                    w_sof_nxt   = (r_state == S_IDLE);
                    if (w_count_inc == c_frame_len) begin
                        w_state_nxt    = S_TAIL;
                        w_tail_idx_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_TAIL: begin
                // Zero tail bits are injected internally; enable_i is ignored here.
                w_encode       = 1'b1;
                w_bit          = 1'b0;
                w_tail_idx_nxt = 1'b1;
                if (r_tail_idx) begin
                    w_eof_nxt      = 1'b1;
                    w_frame_ct_nxt = r_frame_ct + 16'd1;
                    w_count_nxt    = '0;
                    w_tail_idx_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_encode) begin
            w_valid_nxt = 1'b1;
            w_dout_nxt  = {w_bit ^ r_s1 ^ r_s2, w_bit ^ r_s2};
            w_s2_nxt    = r_s1;
            w_s1_nxt    = w_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_tail_idx <= 1'b0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_valid    <= 1'b0;
            r_dout     <= 2'b00;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_frame_ct <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_tail_idx <= w_tail_idx_nxt;
            r_s1       <= w_s1_nxt;
            r_s2       <= w_s2_nxt;
            r_valid    <= w_valid_nxt;
            r_dout     <= w_dout_nxt;
            r_sof      <= w_sof_nxt;
            r_eof      <= w_eof_nxt;
            r_frame_ct <= w_frame_ct_nxt;
        end
    end

    // Derived from the state register only, so there is no path from enable_i.
    assign ready_o    = (r_state != S_TAIL);
    assign valid_o    = r_valid;
    assign d_out      = r_dout;
    assign sof_o      = r_sof;
    assign eof_o      = r_eof;
    assign frame_ct_o = r_frame_ct;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_framed.sv
`default_nettype none
// tb_conv_encoder_framed : checks FRAME_LEN=8 and FRAME_LEN=2 encoders against a
// frame-level convolution model, plus literal vectors, reset, backpressure and wrap.
module tb_conv_encoder_framed;

    localparam int NI        = 2;
    localparam int SRC_DEPTH = 8192;
    localparam int CAP_DEPTH = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       en  = '0;
    logic [1:0]       din = '0;
    logic [1:0]       rdy;
    logic [1:0]       vld;
    logic [1:0]       sof;
    logic [1:0]       eof;
    logic [1:0][1:0]  dout;
    logic [1:0][15:0] fct;

    conv_encoder_framed #(.FRAME_LEN(8)) u8 (
        .clk(clk), .rst(rst), .enable_i(en[0]), .d_in(din[0]),
        .ready_o(rdy[0]), .valid_o(vld[0]), .d_out(dout[0]),
        .sof_o(sof[0]), .eof_o(eof[0]), .frame_ct_o(fct[0])
    );

    conv_encoder_framed #(.FRAME_LEN(2)) u2 (
        .clk(clk), .rst(rst), .enable_i(en[1]), .d_in(din[1]),
        .ready_o(rdy[1]), .valid_o(vld[1]), .d_out(dout[1]),
        .sof_o(sof[1]), .eof_o(eof[1]), .frame_ct_o(fct[1])
    );

    always #5 clk = ~clk;

    // Reference model: per-frame bit array; symbol k is a convolution over bits k, k-1, k-2.
    int        m_flen [NI] = '{8, 2};
    int        m_cnt  [NI];
    int        m_tail [NI];
    bit        m_rdy  [NI];
    bit        m_vld  [NI];
    bit        m_sof  [NI];
    bit        m_eof  [NI];
    bit [1:0]  m_dout [NI];
    bit [15:0] m_fct  [NI];
    bit        m_bits [NI][0:9];

    bit        src_bits [NI][0:SRC_DEPTH-1];
    int        src_wr   [NI];
    int        src_rd   [NI];

    logic [1:0] cap_sym [NI][0:CAP_DEPTH-1];
    bit         cap_sof [NI][0:CAP_DEPTH-1];
    bit         cap_eof [NI][0:CAP_DEPTH-1];
    int         n_cap   [NI];
    int         cyc;
    int         sof_cyc [NI];
    int         eof_cyc [NI];
    logic [15:0] eof_fct [NI];
    int         rdy_low [NI];

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] exp8 [0:9] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01,
                               2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
    logic [1:0] exp2 [0:7] = '{2'b11, 2'b10, 2'b11, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b00};

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    function automatic bit [1:0] sym(input int i, input int k);
        bit b0, b1, b2;
        b0 = m_bits[i][k];
        b1 = (k >= 1) ? m_bits[i][k-1] : 1'b0;
        b2 = (k >= 2) ? m_bits[i][k-2] : 1'b0;
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    function automatic void model_step(input int i);
        m_vld[i] = 1'b0;
        m_sof[i] = 1'b0;
        m_eof[i] = 1'b0;
        if (!rst) begin
            m_cnt[i]  = 0;
            m_tail[i] = 0;
            m_dout[i] = 2'b00;
            m_fct[i]  = 16'd0;
        end else if (m_tail[i] > 0) begin
            m_dout[i] = sym(i, m_flen[i] + 2 - m_tail[i]);
            m_vld[i]  = 1'b1;
            m_tail[i] = m_tail[i] - 1;
            if (m_tail[i] == 0) begin
                m_eof[i] = 1'b1;
                m_fct[i] = m_fct[i] + 16'd1;
            end
        end else if (en[i] && m_rdy[i]) begin
            m_bits[i][m_cnt[i]] = din[i];
            m_dout[i] = sym(i, m_cnt[i]);
            m_vld[i]  = 1'b1;
            m_sof[i]  = (m_cnt[i] == 0);
            m_cnt[i]  = m_cnt[i] + 1;
            src_rd[i] = src_rd[i] + 1;
            if (m_cnt[i] == m_flen[i]) begin
                m_bits[i][m_flen[i]]     = 1'b0;
                m_bits[i][m_flen[i] + 1] = 1'b0;
                m_cnt[i]  = 0;
                m_tail[i] = 2;
            end
        end
        m_rdy[i] = (m_tail[i] == 0);
    endfunction

    // Compare process: model advances on each rising edge, DUT sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) model_step(i);
            #1;
            for (int i = 0; i < NI; i++) begin
                chk("ready_o",    i, rdy[i],  m_rdy[i]);
                chk("valid_o",    i, vld[i],  m_vld[i]);
                chk("d_out",      i, dout[i], m_dout[i]);
                chk("sof_o",      i, sof[i],  m_sof[i]);
                chk("eof_o",      i, eof[i],  m_eof[i]);
                chk("frame_ct_o", i, fct[i],  m_fct[i]);
                if (vld[i] === 1'b1 && n_cap[i] < CAP_DEPTH) begin
                    cap_sym[i][n_cap[i]] = dout[i];
                    cap_sof[i][n_cap[i]] = sof[i];
                    cap_eof[i][n_cap[i]] = eof[i];
                    n_cap[i]++;
                    if (sof[i] === 1'b1) sof_cyc[i] = cyc;
                    if (eof[i] === 1'b1) begin
                        eof_cyc[i] = cyc;
                        eof_fct[i] = fct[i];
                    end
                end
                if (rdy[i] !== 1'b1) rdy_low[i]++;
            end
        end
    end

    task automatic push(input int i, input bit b);
        if (src_wr[i] < SRC_DEPTH) begin
            src_bits[i][src_wr[i]] = b;
            src_wr[i]++;
        end
    endtask

    task automatic drive(input bit [1:0] want);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            en[i]  = want[i] && (src_rd[i] < src_wr[i]);
            din[i] = (src_rd[i] < SRC_DEPTH) ? src_bits[i][src_rd[i]] : 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_ready"}, i, rdy[i],  1);
            chk({tag, "_valid"}, i, vld[i],  0);
            chk({tag, "_dout"},  i, dout[i], 0);
            chk({tag, "_fct"},   i, fct[i],  0);
        end
    endtask

    initial begin
        int b0;
        int b1;
        bit [1:0] want;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;
        drive(2'b00);

        // Known vectors: 8-bit frame plus a 9th bit across the boundary; 2-bit impulse then zeros
        rdy_low[0] = 0;
        b0 = n_cap[0];
        b1 = n_cap[1];
        push(0, 1); push(0, 0); push(0, 1); push(0, 1);
        push(0, 0); push(0, 0); push(0, 1); push(0, 0); push(0, 1);
        push(1, 1); push(1, 0); push(1, 0); push(1, 0);
        repeat (16) drive(2'b11);
        drive(2'b00);
        for (int k = 0; k < 10; k++) chk("vec8_sym", 0, cap_sym[0][b0+k], exp8[k]);
        chk("vec8_sof_first", 0, cap_sof[0][b0],   1);
        chk("vec8_eof_last",  0, cap_eof[0][b0+9], 1);
        chk("vec8_bit9_sym",  0, cap_sym[0][b0+10], 2'b11);
        chk("vec8_bit9_sof",  0, cap_sof[0][b0+10], 1);
        chk("vec8_frames",    0, fct[0], 1);
        chk("vec8_ready_low", 0, rdy_low[0], 2);
        chk("bp_eof_to_sof",  0, sof_cyc[0] - eof_cyc[0], 1);
        for (int k = 0; k < 8; k++) chk("imp2_sym", 1, cap_sym[1][b1+k], exp2[k]);
        chk("imp2_frames", 1, fct[1], 2);

        // Mid-frame reset clears outputs immediately
        push(0, 1); push(0, 1); push(0, 0);
        push(1, 1);
        repeat (3) drive(2'b11);
        @(negedge clk);
        rst = 1'b0;
        en  = 2'b00;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        b0 = n_cap[0];
        b1 = n_cap[1];
        push(0, 0); push(0, 1);
        push(1, 0); push(1, 1);
        repeat (4) drive(2'b11);
        chk("post_rst_sof", 0, cap_sof[0][b0], 1);
        chk("post_rst_sof", 1, cap_sof[1][b1], 1);

        // Frame counter wrap on the FRAME_LEN=2 instance
        repeat (3) drive(2'b00);
        @(negedge clk);
        force u2.r_frame_ct = 16'hfffe;
        m_fct[1] = 16'hfffe;
        @(negedge clk);
        release u2.r_frame_ct;
        push(1, 1); push(1, 1); push(1, 0); push(1, 1);
        repeat (10) drive(2'b10);
        chk("wrap_eof_fct", 1, eof_fct[1], 16'h0000);
        chk("wrap_final",   1, fct[1],     16'h0000);

        // Randomized stream with gaps, enable asserted during tails
        repeat (3000) begin
            for (int i = 0; i < NI; i++)
                if (src_wr[i] - src_rd[i] < 2) push(i, 1'($urandom_range(0, 1)));
            want[0] = ($urandom_range(0, 3) != 0);
            want[1] = ($urandom_range(0, 3) != 0);
            drive(want);
        end
        repeat (6) drive(2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
